// File: rtl/mc_core_hs.sv
// rtl/mc_core_hs.sv - multicycle MIPS-subset core with handshaked unified memory port
module mc_core_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       dbg_pc
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc, ir, a_q, b_q, aluout, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm;
  logic [31:0] alu_y, sub_y, addr32;
  logic        alu_ok;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign simm  = {{16{ir[15]}}, ir[15:0]};
  assign sub_y = a_q - b_q;

  // R-type ALU; an unknown funct flags the instruction as illegal
  always_comb begin
    alu_y  = '0;
    alu_ok = 1'b1;
    case (funct)
      6'h20:   alu_y = a_q + b_q;
      6'h22:   alu_y = sub_y;
      6'h24:   alu_y = a_q & b_q;
      6'h25:   alu_y = a_q | b_q;
      6'h2A:   alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
      default: alu_ok = 1'b0;
    endcase
  end

  // Memory port is a pure decode of the state; reset gates req so it drops mid-access
  assign addr32    = (state == S_FETCH) ? pc : aluout;
  assign mem_adr   = addr32[ADDR_W-1:0];
  assign mem_req   = reset & ((state == S_FETCH) | (state == S_MEMRD) | (state == S_MEMWR));
  assign mem_we    = reset & (state == S_MEMWR);
  assign mem_wdata = b_q;
  assign halted    = (state == S_HALT);
  assign dbg_pc    = pc;

  // Controller FSM, datapath registers and register-file write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
      mdr    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          pc    <= pc + 32'd4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q    <= rf[rs];
          b_q    <= rf[rt];
          aluout <= pc + (simm << 2);
          case (op)
            6'h23, 6'h2B: state <= S_MEMADR;
            6'h00:        state <= S_EXEC;
            6'h04:        state <= S_BRANCH;
            6'h08:        state <= S_ADDIEX;
            6'h02:        state <= S_JUMP;
            default:      state <= S_HALT;
          endcase
        end
        S_MEMADR: begin
          aluout <= a_q + simm;
          state  <= (op == 6'h23) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= S_MEMWB;
        end
        S_MEMWB: begin
          if (rt != 5'd0) rf[rt] <= mdr;
          state <= S_FETCH;
        end
        S_MEMWR: if (mem_ready) state <= S_FETCH;
        S_EXEC: begin
          if (alu_ok) begin
            aluout <= alu_y;
            state  <= S_ALUWB;
          end else begin
            state <= S_HALT;
          end
        end
        S_ALUWB: begin
          if (rd != 5'd0) rf[rd] <= aluout;
          state <= S_FETCH;
        end
        S_BRANCH: begin
          if (sub_y == 32'd0) pc <= aluout;
          state <= S_FETCH;
        end
        S_ADDIEX: begin
          aluout <= a_q + simm;
          state  <= S_ADDIWB;
        end
        S_ADDIWB: begin
          if (rt != 5'd0) rf[rt] <= aluout;
          state <= S_FETCH;
        end
        S_JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
